// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//   Saturating accumulator stage for a multiply-accumulate pipeline. A job is
//   started with a length; that many 16-bit unsigned products are summed into
//   an ACC_W-bit accumulator that clamps at all ones. The result is then
//   offered with a valid/ready handshake.
//
// Parameters
//   ACC_W     accumulator / result width in bits (17 or more)
//   LEN_W     width of the job-length field
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   nreset     in   asynchronous active-low reset
//   start      in   one-cycle job request, sampled only in IDLE
//   len        in   number of products in the job, sampled with start
//   clr        in   synchronous abort back to IDLE (highest priority)
//   in_valid   in   product is valid this cycle
//   product    in   16-bit unsigned product
//   in_ready   out  a product is accepted this cycle (state ACCUM)
//   acc_out    out  accumulator value (registered)
//   out_valid  out  acc_out holds a completed job result (state DONE)
//   out_ready  in   consumer takes acc_out
//   overflow   out  sticky saturation flag for the current or last job
//   busy       out  any state other than IDLE
// ---------------------------------------------------------------------------
module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [15:0]      product,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic             w_beat;
  logic [ACC_W:0]   w_sum;

  // One extra bit on the sum exposes the carry out, which is the saturation
  // condition; the product is zero-extended.
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, product};
  assign w_beat = (r_state == S_ACCUM) && in_valid;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt = '0;
          w_ovf_nxt = 1'b0;
          if (len != '0) begin
            w_count_nxt = len;
            w_state_nxt = S_ACCUM;
          end else begin
            // Empty job: go straight to DONE with a zero result.
            w_count_nxt = '0;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_ACCUM: begin
        if (w_beat) begin
          // Once clamped, any further nonzero product carries out again,
          // so the accumulator stays at all ones without a separate flag.
          if (w_sum[ACC_W]) begin
            w_acc_nxt = '1;
            w_ovf_nxt = 1'b1;
          end else begin
            w_acc_nxt = w_sum[ACC_W-1:0];
          end
          w_count_nxt = r_count - LEN_W'(1);
          if (r_count == LEN_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a beat in the same cycle.
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end
  end

  // Handshake outputs depend on state only.
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
//   Drives a 24-bit and a 17-bit instance with identical stimulus and checks
//   both against a job-level reference: the result of a job is the plain sum
//   of its products clamped to 2^W-1, and overflow is whether the sum ever
//   exceeded that.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic [7:0]  len;
  logic        clr;
  logic        in_valid;
  logic [15:0] product;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, overflow_a, busy_a;
  logic [23:0] acc_a;
  logic        in_ready_b, out_valid_b, overflow_b, busy_b;
  logic [16:0] acc_b;

  logic [3:0]  st_a, st_b;
  assign st_a = {busy_a, in_ready_a, out_valid_a, overflow_a};
  assign st_b = {busy_b, in_ready_b, out_valid_b, overflow_b};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .nreset(nreset), .start(start), .len(len), .clr(clr),
    .in_valid(in_valid), .product(product), .in_ready(in_ready_a),
    .acc_out(acc_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .overflow(overflow_a), .busy(busy_a)
  );

  mac_accumulator #(.ACC_W(17), .LEN_W(8)) dut_b (
    .clk(clk), .nreset(nreset), .start(start), .len(len), .clr(clr),
    .in_valid(in_valid), .product(product), .in_ready(in_ready_b),
    .acc_out(acc_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .overflow(overflow_b), .busy(busy_b)
  );

  function automatic longint unsigned sat_sum(longint unsigned t, int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    return (t > m) ? m : t;
  endfunction

  function automatic logic over(longint unsigned t, int w);
    return t > ((64'd1 << w) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    nreset = 1'b0; start = 1'b0; len = '0; clr = 1'b0;
    in_valid = 1'b0; product = '0; out_ready = 1'b0;
    #2;
    n_checks++; if (st_a !== 4'b0000 || acc_a !== 24'd0) begin n_errors++;
      $display("FAIL reset_a got st=%b acc=%h want st=0000 acc=0", st_a, acc_a); end
    n_checks++; if (st_b !== 4'b0000 || acc_b !== 17'd0) begin n_errors++;
      $display("FAIL reset_b got st=%b acc=%h want st=0000 acc=0", st_b, acc_b); end
    tick(); tick();
    nreset = 1'b1;
    tick();
    n_checks++; if (st_a !== 4'b0000 || st_b !== 4'b0000) begin n_errors++;
      $display("FAIL reset_release got st_a=%b st_b=%b want 0000", st_a, st_b); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_basic();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    n_checks++; if (st_a !== 4'b1100 || st_b !== 4'b1100) begin n_errors++;
      $display("FAIL basic_accum got st_a=%b st_b=%b want 1100", st_a, st_b); end
    in_valid = 1'b1; product = 16'd100;
    tick();
    product = 16'd200;
    tick();
    product = 16'd300;
    n_checks++; if (st_a !== 4'b1100 || acc_a !== 24'd300 || acc_b !== 17'd300) begin n_errors++;
      $display("FAIL basic_two_beats got st=%b acc_a=%0d acc_b=%0d want st=1100 acc=300", st_a, acc_a, acc_b); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (st_a !== 4'b1010 || acc_a !== 24'd600) begin n_errors++;
      $display("FAIL basic_done_a got st=%b acc=%0d want st=1010 acc=600", st_a, acc_a); end
    n_checks++; if (st_b !== 4'b1010 || acc_b !== 17'd600) begin n_errors++;
      $display("FAIL basic_done_b got st=%b acc=%0d want st=1010 acc=600", st_b, acc_b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (st_a !== 4'b0000 || acc_a !== 24'd600 || st_b !== 4'b0000 || acc_b !== 17'd600) begin n_errors++;
      $display("FAIL basic_idle got st_a=%b acc_a=%0d st_b=%b acc_b=%0d want 0000/600", st_a, acc_a, st_b, acc_b); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_backpressure();
    out_ready = 1'b0;
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; product = 16'hFFFF;
    tick();
    in_valid = 1'b0; product = 16'h1234;
    tick();
    n_checks++; if (st_a !== 4'b1100 || acc_a !== 24'h00FFFF || acc_b !== 17'h0FFFF) begin n_errors++;
      $display("FAIL bp_gap got st=%b acc_a=%h acc_b=%h want 1100/ffff", st_a, acc_a, acc_b); end
    in_valid = 1'b1; product = 16'h0001;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (st_a !== 4'b1010 || acc_a !== 24'h010000 || st_b !== 4'b1010 || acc_b !== 17'h10000) begin n_errors++;
        $display("FAIL bp_hold%0d got st_a=%b acc_a=%h st_b=%b acc_b=%h want 1010/10000", i, st_a, acc_a, st_b, acc_b); end
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (st_a !== 4'b0000 || acc_a !== 24'h010000 || st_b !== 4'b0000) begin n_errors++;
      $display("FAIL bp_idle got st_a=%b acc_a=%h st_b=%b want 0000/10000", st_a, acc_a, st_b); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_saturation();
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; product = 16'hFFFF;
    tick(); tick(); tick();
    n_checks++; if (st_b !== 4'b1101 || acc_b !== 17'h1FFFF) begin n_errors++;
      $display("FAIL sat_third_b got st=%b acc=%h want 1101/1ffff", st_b, acc_b); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (st_b !== 4'b1011 || acc_b !== 17'h1FFFF) begin n_errors++;
      $display("FAIL sat_done_b got st=%b acc=%h want 1011/1ffff", st_b, acc_b); end
    n_checks++; if (st_a !== 4'b1010 || acc_a !== 24'h03FFFC) begin n_errors++;
      $display("FAIL sat_done_a got st=%b acc=%h want 1010/3fffc", st_a, acc_a); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (st_b !== 4'b0001 || acc_b !== 17'h1FFFF) begin n_errors++;
      $display("FAIL sat_idle_b got st=%b acc=%h want 0001/1ffff", st_b, acc_b); end
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    n_checks++; if (st_b !== 4'b1100 || acc_b !== 17'd0) begin n_errors++;
      $display("FAIL sat_restart_b got st=%b acc=%h want 1100/0", st_b, acc_b); end
    in_valid = 1'b1; product = 16'd5;
    tick();
    in_valid = 1'b0;
    n_checks++; if (st_a !== 4'b1010 || acc_a !== 24'd5 || st_b !== 4'b1010 || acc_b !== 17'd5) begin n_errors++;
      $display("FAIL sat_next_job got st_a=%b acc_a=%0d st_b=%b acc_b=%0d want 1010/5", st_a, acc_a, st_b, acc_b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_zero_len();
    start = 1'b1; len = 8'd0;
    #1;
    n_checks++; if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin n_errors++;
      $display("FAIL zero_ready_idle got %b%b want 00", in_ready_a, in_ready_b); end
    tick();
    start = 1'b0;
    n_checks++; if (st_a !== 4'b1010 || acc_a !== 24'd0 || st_b !== 4'b1010 || acc_b !== 17'd0) begin n_errors++;
      $display("FAIL zero_done got st_a=%b acc_a=%h st_b=%b acc_b=%h want 1010/0", st_a, acc_a, st_b, acc_b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (st_a !== 4'b0000 || st_b !== 4'b0000) begin n_errors++;
      $display("FAIL zero_idle got st_a=%b st_b=%b want 0000", st_a, st_b); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_abort_reset();
    start = 1'b1; len = 8'd5;
    tick();
    in_valid = 1'b1; product = 16'd1000;
    len = 8'd1;  // start still high: a reload would finish after this beat
    tick();
    start = 1'b0;
    n_checks++; if (st_a !== 4'b1100 || acc_a !== 24'd1000) begin n_errors++;
      $display("FAIL abort_start_ignored got st=%b acc=%0d want 1100/1000", st_a, acc_a); end
    product = 16'd2000; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    n_checks++; if (st_a !== 4'b0000 || acc_a !== 24'd0 || st_b !== 4'b0000 || acc_b !== 17'd0) begin n_errors++;
      $display("FAIL abort_clr got st_a=%b acc_a=%0d st_b=%b acc_b=%0d want 0000/0", st_a, acc_a, st_b, acc_b); end
    tick();
    n_checks++; if (st_a !== 4'b0000 || acc_a !== 24'd0) begin n_errors++;
      $display("FAIL abort_stay got st=%b acc=%0d want 0000/0", st_a, acc_a); end

    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd777;
    tick(); tick();
    n_checks++; if (acc_a !== 24'd1554 || st_a !== 4'b1100) begin n_errors++;
      $display("FAIL rst_pre got st=%b acc=%0d want 1100/1554", st_a, acc_a); end
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (st_a !== 4'b0000 || acc_a !== 24'd0 || st_b !== 4'b0000 || acc_b !== 17'd0) begin n_errors++;
      $display("FAIL rst_async got st_a=%b acc_a=%0d st_b=%b acc_b=%0d want 0000/0", st_a, acc_a, st_b, acc_b); end
    #3 nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (st_a !== 4'b0000 || st_b !== 4'b0000 || acc_a !== 24'd0) begin n_errors++;
        $display("FAIL rst_after%0d got st_a=%b st_b=%b acc=%0d want 0000/0", i, st_a, st_b, acc_a); end
    end
    in_valid = 1'b0;
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd7;
    tick();
    in_valid = 1'b0;
    n_checks++; if (st_a !== 4'b1010 || acc_a !== 24'd7 || acc_b !== 17'd7) begin n_errors++;
      $display("FAIL rst_new_job got st=%b acc_a=%0d acc_b=%0d want 1010/7", st_a, acc_a, acc_b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_random();
    longint unsigned total;
    int              jlen, beats, guard, hold;
    for (int j = 0; j < 1000; j++) begin
      jlen  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 10));
      total = 0;
      out_ready = 1'b0;
      start = 1'b1; len = 8'(jlen);
      tick();
      beats = 0;
      guard = 0;
      while (beats < jlen && guard < 1000) begin
        in_valid = ($urandom_range(0, 2) != 0);
        product  = 16'($urandom);
        start    = ($urandom_range(0, 3) == 0);
        len      = 8'($urandom);
        n_checks++; if (st_a[3:1] !== 3'b110 || st_b[3:1] !== 3'b110) begin n_errors++;
          $display("FAIL rnd_accum job %0d got st_a=%b st_b=%b want 110x", j, st_a, st_b); end
        tick();
        if (in_valid) begin
          total += product;
          beats++;
        end
        guard++;
      end
      if (guard >= 1000) begin
        n_errors++;
        $display("FAIL rnd_budget job %0d got beats=%0d want %0d", j, beats, jlen);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        n_checks++; if (st_a !== {3'b101, over(total, 24)} || acc_a !== 24'(sat_sum(total, 24))) begin n_errors++;
          $display("FAIL rnd_result_a job %0d got st=%b acc=%h want st=101%b acc=%h", j, st_a, acc_a, over(total, 24), 24'(sat_sum(total, 24))); end
        n_checks++; if (st_b !== {3'b101, over(total, 17)} || acc_b !== 17'(sat_sum(total, 17))) begin n_errors++;
          $display("FAIL rnd_result_b job %0d got st=%b acc=%h want st=101%b acc=%h", j, st_b, acc_b, over(total, 17), 17'(sat_sum(total, 17))); end
        if (h == hold) out_ready = 1'b1;
        tick();
      end
      out_ready = 1'b0;
      n_checks++; if (st_a[3:1] !== 3'b000 || st_b[3:1] !== 3'b000) begin n_errors++;
        $display("FAIL rnd_idle job %0d got st_a=%b st_b=%b want 000x", j, st_a, st_b); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_zero_len();
    test_abort_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
